// File: rtl/vcache_stat_print_sequencer_if.sv
// Bundle of request-side and profiler-side signals of the print-stat sequencer.
// The slave modport is the sequencer itself. The master modport is the environment,
// meaning the requesters plus the profiler array.
interface vcache_stat_print_sequencer_if #(
    parameter int num_req_p    = 4,
    parameter int num_cache_p  = 8,
    parameter int data_width_p = 32
);
    logic [num_req_p-1:0]              req_v_i;
    logic [num_req_p*data_width_p-1:0] req_tag_i;
    logic [num_req_p-1:0]              req_yumi_o;
    logic [31:0]                       global_ctr_o;
    logic [num_cache_p-1:0]            print_stat_v_o;
    logic [data_width_p-1:0]           print_stat_tag_o;
    logic                              busy_o;

    modport slave (
        input  req_v_i, req_tag_i,
        output req_yumi_o, global_ctr_o, print_stat_v_o, print_stat_tag_o, busy_o
    );

    modport master (
        output req_v_i, req_tag_i,
        input  req_yumi_o, global_ctr_o, print_stat_v_o, print_stat_tag_o, busy_o
    );
endinterface

// File: rtl/vcache_stat_print_sequencer.sv
// Round-robin arbiter over print-stat requesters. Each granted request is
// serialized onto the vcache profilers one strobe per cycle, because all of
// them append to one shared stats file. The block also owns the free-running
// global cycle counter that is broadcast to every profiler.
module vcache_stat_print_sequencer #(
    parameter int num_req_p    = 4,
    parameter int num_cache_p  = 8,
    parameter int data_width_p = 32,
    parameter int gap_cycles_p = 2
) (
    input  logic clk_i,
    input  logic reset_i,
    vcache_stat_print_sequencer_if.slave bus
);
    localparam int LW = (num_req_p   > 1) ? $clog2(num_req_p)   : 1;
    localparam int IW = (num_cache_p > 1) ? $clog2(num_cache_p) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRINT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t                  state_reg;
    logic [IW-1:0]           idx_reg;
    logic [31:0]             gcnt_reg;
    logic [LW-1:0]           last_reg;
    logic [data_width_p-1:0] tag_reg;
    logic [num_cache_p-1:0]  print_v_reg;
    logic [31:0]             global_ctr_reg;

    logic [num_req_p-1:0]    hi_mask;
    logic [num_req_p-1:0]    masked_req;
    logic [data_width_p-1:0] tag_arr [num_req_p];
    logic [LW-1:0]           masked_idx;
    logic [LW-1:0]           any_idx;
    logic [LW-1:0]           grant_idx;
    logic                    grant_v;

    // The mask selects requesters strictly after the last grant. Those requesters get
    // first pick. The tag bus is split into one lane per requester.
    genvar gi;
    generate
        for (gi = 0; gi < num_req_p; gi++) begin : g_req
            assign hi_mask[gi]        = (LW'(gi) > last_reg);
            assign tag_arr[gi]        = bus.req_tag_i[gi*data_width_p +: data_width_p];
            assign bus.req_yumi_o[gi] = grant_v && (grant_idx == LW'(gi));
        end
    endgenerate

    assign masked_req = bus.req_v_i & hi_mask;

    // Find the lowest set bit of the masked request vector. When nothing is set above
    // the pointer, wrap around and take the lowest set bit of the full request vector.
    always_comb begin
        masked_idx = '0;
        any_idx    = '0;
        for (int j = num_req_p - 1; j >= 0; j--) begin
            if (masked_req[j]) begin
                masked_idx = LW'(j);
            end
            if (bus.req_v_i[j]) begin
                any_idx = LW'(j);
            end
        end
        grant_idx = (|masked_req) ? masked_idx : any_idx;
        grant_v   = (state_reg == ST_IDLE) && (|bus.req_v_i) && !reset_i;
    end

    // Free-running cycle counter that wraps modulo 2^32.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            global_ctr_reg <= '0;
        end else begin
            global_ctr_reg <= global_ctr_reg + 32'd1;
        end
    end

    // Grant, strobe and gap sequencing. The strobe is a registered one-hot value that
    // shifts left once per PRINT cycle.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_reg   <= ST_IDLE;
            idx_reg     <= '0;
            gcnt_reg    <= '0;
            last_reg    <= LW'(num_req_p - 1);
            tag_reg     <= '0;
            print_v_reg <= '0;
        end else begin
            unique case (state_reg)
                ST_IDLE: begin
                    if (grant_v) begin
                        tag_reg     <= tag_arr[grant_idx];
                        last_reg    <= grant_idx;
                        idx_reg     <= '0;
                        print_v_reg <= num_cache_p'(1);
                        state_reg   <= ST_PRINT;
                    end
                end
                ST_PRINT: begin
                    if (idx_reg == IW'(num_cache_p - 1)) begin
                        print_v_reg <= '0;
                        if (gap_cycles_p == 0) begin
                            state_reg <= ST_IDLE;
                        end else begin
                            gcnt_reg  <= 32'(gap_cycles_p);
                            state_reg <= ST_GAP;
                        end
                    end else begin
                        idx_reg     <= idx_reg + IW'(1);
                        print_v_reg <= print_v_reg << 1;
                    end
                end
                ST_GAP: begin
                    if (gcnt_reg <= 32'd1) begin
                        state_reg <= ST_IDLE;
                    end else begin
                        gcnt_reg <= gcnt_reg - 32'd1;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.global_ctr_o     = global_ctr_reg;
    assign bus.print_stat_v_o   = print_v_reg;
    assign bus.print_stat_tag_o = tag_reg;
    assign bus.busy_o           = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_vcache_stat_print_sequencer.sv
// Directed bench for vcache_stat_print_sequencer with num_req_p=4, num_cache_p=8,
// data_width_p=32 and gap_cycles_p=2. Inputs are driven and outputs are sampled
// 1 ns after the rising edge.
module tb_vcache_stat_print_sequencer;
    localparam int NR  = 4;
    localparam int NC  = 8;
    localparam int DW  = 32;
    localparam int GAP = 2;

    logic clk_i;
    logic reset_i;
    int   checks;
    int   errors;
    int   cyc;

    vcache_stat_print_sequencer_if #(.num_req_p(NR), .num_cache_p(NC), .data_width_p(DW)) bus ();

    vcache_stat_print_sequencer #(
        .num_req_p   (NR),
        .num_cache_p (NC),
        .data_width_p(DW),
        .gap_cycles_p(GAP)
    ) dut (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .bus    (bus)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc++;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wait_idle();
        for (int w = 0; w < 40 && bus.busy_o; w++) step();
        checks++;
        if (bus.busy_o !== 1'b0) begin
            errors++;
            $display("FAIL wait_idle: busy_o=%b after 40 cycles, required 0", bus.busy_o);
        end
    endtask

    task automatic test_reset();
        reset_i       = 1'b1;
        bus.req_v_i   = '0;
        bus.req_tag_i = '0;
        step();
        step();
        reset_i = 1'b0;
        repeat (10) step();
        checks++;
        if (bus.global_ctr_o !== 32'd10) begin
            errors++; $display("FAIL reset_ctr: got %0d, required 10", bus.global_ctr_o);
        end
        checks++;
        if (bus.print_stat_v_o !== 8'h00 || bus.busy_o !== 1'b0 || bus.req_yumi_o !== 4'h0) begin
            errors++;
            $display("FAIL reset_outputs: v=%h busy=%b yumi=%b, required 00 0 0000",
                     bus.print_stat_v_o, bus.busy_o, bus.req_yumi_o);
        end
        checks++;
        if (bus.print_stat_tag_o !== 32'h0) begin
            errors++; $display("FAIL reset_tag: got %h, required 0", bus.print_stat_tag_o);
        end
    endtask

    task automatic test_single();
        bus.req_v_i         = 4'b0001;
        bus.req_tag_i[31:0] = 32'hAB;
        #1;
        checks++;
        if (bus.req_yumi_o !== 4'b0001) begin
            errors++; $display("FAIL single_yumi: got %b, required 0001", bus.req_yumi_o);
        end
        step();
        bus.req_v_i = '0;
        for (int k = 0; k < NC; k++) begin
            checks++;
            if (bus.print_stat_v_o !== (8'h01 << k) || bus.print_stat_tag_o !== 32'hAB
                || bus.busy_o !== 1'b1) begin
                errors++;
                $display("FAIL single_strobe%0d: v=%h tag=%h busy=%b, required %h 000000ab 1",
                         k, bus.print_stat_v_o, bus.print_stat_tag_o, bus.busy_o, 8'h01 << k);
            end
            step();
        end
        for (int g = 0; g < GAP; g++) begin
            checks++;
            if (bus.print_stat_v_o !== 8'h00 || bus.busy_o !== 1'b1) begin
                errors++;
                $display("FAIL single_gap%0d: v=%h busy=%b, required 00 1",
                         g, bus.print_stat_v_o, bus.busy_o);
            end
            step();
        end
        checks++;
        if (bus.busy_o !== 1'b0) begin
            errors++; $display("FAIL single_idle_t11: busy=%b, required 0", bus.busy_o);
        end
    endtask

    task automatic test_round_robin();
        int prev;
        int expg;
        bit found;
        prev    = 0;
        reset_i = 1'b1;
        step();
        reset_i = 1'b0;
        for (int i = 0; i < NR; i++) bus.req_tag_i[i*DW +: DW] = 32'h100 + 32'(i);
        bus.req_v_i = 4'b1111;
        #1;
        for (int g = 0; g < 5; g++) begin
            expg  = g % NR;
            found = 1'b0;
            for (int w = 0; w < 20 && !found; w++) begin
                if (bus.req_yumi_o != 4'b0000) found = 1'b1;
                else step();
            end
            checks++;
            if (bus.req_yumi_o !== (4'b0001 << expg)) begin
                errors++;
                $display("FAIL rr_grant%0d: yumi=%b, required %b", g, bus.req_yumi_o, 4'b0001 << expg);
            end
            if (g > 0) begin
                checks++;
                if (cyc - prev != 11) begin
                    errors++; $display("FAIL rr_spacing%0d: got %0d cycles, required 11", g, cyc - prev);
                end
            end
            prev = cyc;
            step();
            checks++;
            if (bus.print_stat_tag_o !== 32'h100 + 32'(expg) || bus.print_stat_v_o !== 8'h01) begin
                errors++;
                $display("FAIL rr_tag%0d: tag=%h v=%h, required %h 01",
                         g, bus.print_stat_tag_o, bus.print_stat_v_o, 32'h100 + 32'(expg));
            end
        end
        bus.req_v_i = '0;
        wait_idle();
    endtask

    task automatic test_wait_while_busy();
        int bad;
        bad                 = 0;
        bus.req_v_i         = 4'b0001;
        bus.req_tag_i[31:0] = 32'h11;
        #1;
        checks++;
        if (bus.req_yumi_o !== 4'b0001) begin
            errors++; $display("FAIL busy_first_yumi: got %b, required 0001", bus.req_yumi_o);
        end
        step();
        bus.req_v_i = '0;
        step();
        step();
        bus.req_v_i          = 4'b0100;
        bus.req_tag_i[95:64] = 32'h55;
        #1;
        for (int c = 3; c <= 10; c++) begin
            if (bus.req_yumi_o !== 4'b0000) bad++;
            step();
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL busy_no_yumi: %0d cycles granted while busy, required 0", bad);
        end
        checks++;
        if (bus.req_yumi_o !== 4'b0100 || bus.busy_o !== 1'b0) begin
            errors++;
            $display("FAIL busy_first_idle_yumi: yumi=%b busy=%b, required 0100 0",
                     bus.req_yumi_o, bus.busy_o);
        end
        step();
        bus.req_v_i = '0;
        checks++;
        if (bus.print_stat_tag_o !== 32'h55 || bus.print_stat_v_o !== 8'h01) begin
            errors++;
            $display("FAIL busy_tag2: tag=%h v=%h, required 00000055 01",
                     bus.print_stat_tag_o, bus.print_stat_v_o);
        end
        wait_idle();
    endtask

    task automatic test_reset_mid_print();
        bus.req_v_i          = 4'b0001;
        bus.req_tag_i[31:0]  = 32'hAB;
        bus.req_tag_i[63:32] = 32'h77;
        #1;
        checks++;
        if (bus.req_yumi_o !== 4'b0001) begin
            errors++; $display("FAIL rst_mid_yumi: got %b, required 0001", bus.req_yumi_o);
        end
        step();
        bus.req_v_i = '0;
        repeat (3) step();
        checks++;
        if (bus.print_stat_v_o !== 8'h08) begin
            errors++; $display("FAIL rst_mid_strobe3: got %h, required 08", bus.print_stat_v_o);
        end
        reset_i = 1'b1;
        step();
        checks++;
        if (bus.print_stat_v_o !== 8'h00 || bus.busy_o !== 1'b0 || bus.print_stat_tag_o !== 32'h0
            || bus.global_ctr_o !== 32'h0 || bus.req_yumi_o !== 4'h0) begin
            errors++;
            $display("FAIL rst_mid_outputs: v=%h busy=%b tag=%h ctr=%h yumi=%b, required all zero",
                     bus.print_stat_v_o, bus.busy_o, bus.print_stat_tag_o, bus.global_ctr_o,
                     bus.req_yumi_o);
        end
        reset_i     = 1'b0;
        bus.req_v_i = 4'b0110;
        #1;
        checks++;
        if (bus.req_yumi_o !== 4'b0010) begin
            errors++; $display("FAIL rst_mid_regrant: yumi=%b, required 0010", bus.req_yumi_o);
        end
        step();
        bus.req_v_i = '0;
        checks++;
        if (bus.print_stat_tag_o !== 32'h77) begin
            errors++; $display("FAIL rst_mid_tag1: got %h, required 00000077", bus.print_stat_tag_o);
        end
        wait_idle();
    endtask

    task automatic test_ctr_wrap();
        force dut.global_ctr_reg = 32'hFFFF_FFFE;
        #1;
        checks++;
        if (bus.global_ctr_o !== 32'hFFFF_FFFE) begin
            errors++; $display("FAIL wrap_load: got %h, required fffffffe", bus.global_ctr_o);
        end
        release dut.global_ctr_reg;
        step();
        checks++;
        if (bus.global_ctr_o !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL wrap_max: got %h, required ffffffff", bus.global_ctr_o);
        end
        step();
        checks++;
        if (bus.global_ctr_o !== 32'h0000_0000) begin
            errors++; $display("FAIL wrap_zero: got %h, required 00000000", bus.global_ctr_o);
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        cyc     = 0;
        reset_i = 1'b1;
        test_reset();
        test_single();
        test_round_robin();
        test_wait_while_busy();
        test_reset_mid_print();
        test_ctr_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
